// File: rtl/mem_stage_hs.sv
// Memory stage with valid/ready data-memory handshake, load extraction and store lane steering.
// Optional build macro MEM_MISALIGN_TRAP_EN: misaligned half/word/double accesses trap instead of issuing.
module mem_stage_hs #(
  parameter int XLEN                  = 32,
  parameter int BE_W                  = XLEN / 8,
  parameter int CONTROL_SIGNALS_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [XLEN-1:0]                  ex_mem_pc,
  input  logic [XLEN-1:0]                  ex_mem_alu_result,
  input  logic [XLEN-1:0]                  ex_mem_rs2_data,
  input  logic [4:0]                       ex_mem_rd_addr,
  input  logic [CONTROL_SIGNALS_WIDTH-1:0] ex_mem_control_signals,
  input  logic                             ex_mem_valid,
  input  logic                             mem_flush,
  output logic                             mem_stall,
  output logic                             dmem_req_valid,
  input  logic                             dmem_req_ready,
  output logic [XLEN-1:0]                  dmem_addr,
  output logic [XLEN-1:0]                  dmem_wdata,
  output logic                             dmem_we,
  output logic [BE_W-1:0]                  dmem_be,
  input  logic                             dmem_rsp_valid,
  input  logic [XLEN-1:0]                  dmem_rdata,
  output logic [XLEN-1:0]                  mem_wb_pc,
  output logic [XLEN-1:0]                  mem_wb_alu_result,
  output logic [XLEN-1:0]                  mem_wb_mem_data,
  output logic [4:0]                       mem_wb_rd_addr,
  output logic [CONTROL_SIGNALS_WIDTH-1:0] mem_wb_control_signals,
  output logic                             mem_wb_valid,
  output logic                             mem_wb_misaligned
);

  // Control-word layout: [0] read, [1] write, [4:2] width code, [5] unsigned load.
  localparam int CTRL_MEM_READ      = 0;
  localparam int CTRL_MEM_WRITE     = 1;
  localparam int CTRL_MEM_WIDTH_LSB = 2;
  localparam int CTRL_MEM_UNSIGNED  = 5;

  localparam logic [2:0] MEM_BYTE   = 3'b000;
  localparam logic [2:0] MEM_HALF   = 3'b001;
  localparam logic [2:0] MEM_WORD   = 3'b010;
  localparam logic [2:0] MEM_DOUBLE = 3'b011;

  localparam int OFF_W = $clog2(BE_W);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  function automatic logic [BE_W-1:0] byte_enables(input logic [1:0] size,
                                                   input logic [OFF_W-1:0] lane);
    logic [BE_W-1:0] be;
    int lo;
    int n;
    be = '0;
    lo = int'(lane);
    n  = 1 << size;
    for (int i = 0; i < BE_W; i++) begin
      if (i >= lo && i < lo + n) be[i] = 1'b1;
    end
    return be;
  endfunction

  function automatic logic [XLEN-1:0] store_lanes(input logic [1:0] size,
                                                  input logic [XLEN-1:0] d);
    logic [XLEN-1:0] r;
    case (size)
      2'd0:    r = {BE_W{d[7:0]}};
      2'd1:    r = {(BE_W/2){d[15:0]}};
      2'd2:    r = {(BE_W/4){d[31:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  // Shift the addressed lane down, then extend from the top bit of the access size.
  function automatic logic [XLEN-1:0] load_extract(input logic [1:0] size,
                                                   input logic [OFF_W-1:0] lane,
                                                   input logic is_unsigned,
                                                   input logic [XLEN-1:0] rdata);
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] mask;
    logic [XLEN-1:0] top;
    logic            sign;
    shifted = rdata >> {lane, 3'b000};
    mask    = '0;
    for (int i = 0; i < BE_W; i++) begin
      if (i < (1 << size)) mask[i*8 +: 8] = 8'hFF;
    end
    top  = mask & ~(mask >> 1);
    sign = |(shifted & top);
    return (is_unsigned || !sign) ? (shifted & mask) : (shifted | ~mask);
  endfunction

  state_t                     state_q, state_d;
  logic                       kill_q, kill_d;
  logic [XLEN-1:0]            wb_pc_q, wb_alu_q, wb_data_q;
  logic [4:0]                 wb_rd_q;
  logic [CONTROL_SIGNALS_WIDTH-1:0] wb_ctrl_q;
  logic                       wb_valid_q;

  logic [2:0]       width_code;
  logic [1:0]       size;
  logic [OFF_W-1:0] offset, align_mask, lane;
  logic             is_store, mem_op, trap, kill_now;
  logic             req_valid, retire, wb_valid, load_done;

  assign width_code = ex_mem_control_signals[CTRL_MEM_WIDTH_LSB +: 3];
  assign is_store   = ex_mem_control_signals[CTRL_MEM_WRITE];
  assign mem_op     = ex_mem_valid && (ex_mem_control_signals[CTRL_MEM_READ] || is_store);
  assign offset     = ex_mem_alu_result[OFF_W-1:0];
  assign kill_now   = kill_q || mem_flush;

  always_comb begin
    size = 2'd2;
    case (width_code)
      MEM_BYTE:   size = 2'd0;
      MEM_HALF:   size = 2'd1;
      MEM_WORD:   size = 2'd2;
      MEM_DOUBLE: size = (XLEN == 64) ? 2'd3 : 2'd2;
      default:    size = 2'd2;
    endcase
  end

  assign align_mask = OFF_W'((1 << size) - 1);
  assign lane       = offset & ~align_mask;

`ifdef MEM_MISALIGN_TRAP_EN
  logic wb_mis_q;
  assign trap = mem_op && (|(offset & align_mask));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wb_mis_q <= 1'b0;
    else          wb_mis_q <= (state_q == S_IDLE) && trap && !mem_flush;
  end
  assign mem_wb_misaligned = wb_mis_q;
`else
  assign trap              = 1'b0;
  assign mem_wb_misaligned = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (mem_op && !mem_flush && !trap) begin
          if (!dmem_req_ready) state_d = S_REQ;
          else if (!is_store)  state_d = S_WAIT;
        end
      end
      S_REQ:   if (dmem_req_ready) state_d = is_store ? S_IDLE : S_WAIT;
      S_WAIT:  if (dmem_rsp_valid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A flush in IDLE suppresses the request; later flushes only mark the result as killed.
  always_comb begin
    req_valid = 1'b0;
    retire    = 1'b0;
    wb_valid  = 1'b0;
    load_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_valid = mem_op && !mem_flush && !trap;
        retire    = !mem_op || mem_flush || trap || (dmem_req_ready && is_store);
        wb_valid  = ex_mem_valid && !mem_flush && retire;
      end
      S_REQ: begin
        req_valid = 1'b1;
        retire    = dmem_req_ready && is_store;
        wb_valid  = retire && !kill_now;
      end
      S_WAIT: begin
        retire    = dmem_rsp_valid;
        load_done = dmem_rsp_valid && !kill_now;
        wb_valid  = load_done;
      end
      default: ;
    endcase
  end

  always_comb begin
    kill_d = kill_q;
    if (retire)                               kill_d = 1'b0;
    else if (state_q != S_IDLE && mem_flush)  kill_d = 1'b1;
  end

  assign mem_stall      = !retire;
  assign dmem_req_valid = reset_n && req_valid;
  assign dmem_addr      = ex_mem_alu_result;
  assign dmem_we        = is_store;
  assign dmem_be        = byte_enables(size, lane);
  assign dmem_wdata     = store_lanes(size, ex_mem_rs2_data);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_pc_q    <= '0;
      wb_alu_q   <= '0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      wb_ctrl_q  <= '0;
      wb_valid_q <= 1'b0;
    end else begin
      wb_pc_q    <= ex_mem_pc;
      wb_alu_q   <= ex_mem_alu_result;
      wb_rd_q    <= ex_mem_rd_addr;
      wb_ctrl_q  <= ex_mem_control_signals;
      wb_valid_q <= wb_valid;
      wb_data_q  <= load_done ? load_extract(size, lane,
                                             ex_mem_control_signals[CTRL_MEM_UNSIGNED],
                                             dmem_rdata)
                              : '0;
    end
  end

  assign mem_wb_pc              = wb_pc_q;
  assign mem_wb_alu_result      = wb_alu_q;
  assign mem_wb_mem_data        = wb_data_q;
  assign mem_wb_rd_addr         = wb_rd_q;
  assign mem_wb_control_signals = wb_ctrl_q;
  assign mem_wb_valid           = wb_valid_q;

endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed bench for mem_stage_hs: a 32-bit instance for handshake/flush/reset cases
// and a 64-bit instance for lane selection and extension at doubleword width.
module tb_mem_stage_hs;

  localparam logic [2:0] W_B = 3'b000;
  localparam logic [2:0] W_H = 3'b001;
  localparam logic [2:0] W_W = 3'b010;
  localparam logic [2:0] W_D = 3'b011;

  logic clk, reset_n;

  logic [31:0] pc, alu, rs2, addr, wdata, rdata, wb_pc, wb_alu, wb_data;
  logic [4:0]  rd, wb_rd;
  logic [7:0]  ctrl, wb_ctrl;
  logic        valid, flush, stall, req_valid, ready, we, rsp_valid, wb_valid, wb_mis;
  logic [3:0]  be;

  logic [63:0] d64_pc, d64_alu, d64_rs2, d64_addr, d64_wdata, d64_rdata;
  logic [63:0] d64_wb_pc, d64_wb_alu, d64_wb_data;
  logic [4:0]  d64_rd, d64_wb_rd;
  logic [7:0]  d64_ctrl, d64_wb_ctrl;
  logic        d64_valid, d64_flush, d64_stall, d64_req_valid, d64_ready, d64_we;
  logic        d64_rsp_valid, d64_wb_valid, d64_wb_mis;
  logic [7:0]  d64_be;

  int n_tests = 0;
  int n_fail  = 0;

  mem_stage_hs #(.XLEN(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .ex_mem_pc(pc), .ex_mem_alu_result(alu), .ex_mem_rs2_data(rs2),
    .ex_mem_rd_addr(rd), .ex_mem_control_signals(ctrl), .ex_mem_valid(valid),
    .mem_flush(flush), .mem_stall(stall),
    .dmem_req_valid(req_valid), .dmem_req_ready(ready),
    .dmem_addr(addr), .dmem_wdata(wdata), .dmem_we(we), .dmem_be(be),
    .dmem_rsp_valid(rsp_valid), .dmem_rdata(rdata),
    .mem_wb_pc(wb_pc), .mem_wb_alu_result(wb_alu), .mem_wb_mem_data(wb_data),
    .mem_wb_rd_addr(wb_rd), .mem_wb_control_signals(wb_ctrl),
    .mem_wb_valid(wb_valid), .mem_wb_misaligned(wb_mis)
  );

  mem_stage_hs #(.XLEN(64)) dut64 (
    .clk(clk), .reset_n(reset_n),
    .ex_mem_pc(d64_pc), .ex_mem_alu_result(d64_alu), .ex_mem_rs2_data(d64_rs2),
    .ex_mem_rd_addr(d64_rd), .ex_mem_control_signals(d64_ctrl), .ex_mem_valid(d64_valid),
    .mem_flush(d64_flush), .mem_stall(d64_stall),
    .dmem_req_valid(d64_req_valid), .dmem_req_ready(d64_ready),
    .dmem_addr(d64_addr), .dmem_wdata(d64_wdata), .dmem_we(d64_we), .dmem_be(d64_be),
    .dmem_rsp_valid(d64_rsp_valid), .dmem_rdata(d64_rdata),
    .mem_wb_pc(d64_wb_pc), .mem_wb_alu_result(d64_wb_alu), .mem_wb_mem_data(d64_wb_data),
    .mem_wb_rd_addr(d64_wb_rd), .mem_wb_control_signals(d64_wb_ctrl),
    .mem_wb_valid(d64_wb_valid), .mem_wb_misaligned(d64_wb_mis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ctl(input logic r, input logic w, input logic [2:0] wc,
                                     input logic u);
    return {2'b00, u, wc, w, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid = 0; ctrl = 0; flush = 0; ready = 0; rsp_valid = 0;
    pc = 0; alu = 0; rs2 = 0; rd = 0; rdata = 0;
    d64_valid = 0; d64_ctrl = 0; d64_flush = 0; d64_ready = 0; d64_rsp_valid = 0;
    d64_pc = 0; d64_alu = 0; d64_rs2 = 0; d64_rd = 0; d64_rdata = 0;
  endtask

  task automatic set_op(input logic [31:0] p, input logic [31:0] a, input logic [31:0] d,
                        input logic [4:0] r, input logic [7:0] c);
    pc = p; alu = a; rs2 = d; rd = r; ctrl = c; valid = 1;
  endtask

  task automatic set_op64(input logic [63:0] a, input logic [63:0] d, input logic [7:0] c);
    d64_pc = 64'h1000; d64_alu = a; d64_rs2 = d; d64_rd = 5'd3; d64_ctrl = c; d64_valid = 1;
  endtask

  initial begin
    idle();
    reset_n = 0;
    set_op(32'h1234, 32'h100, 32'h55, 5'd1, ctl(0, 1, W_W, 0));
    ready = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_valid", req_valid, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_pc", wb_pc, 0);
    check("rst_wb_ctrl", wb_ctrl, 0);
    idle();
    reset_n = 1;
    tick();

    // Store word, accepted immediately
    set_op(32'h40, 32'h100, 32'hDEADBEEF, 5'd5, ctl(0, 1, W_W, 0));
    ready = 1;
    #1;
    check("sw_req_valid", req_valid, 1);
    check("sw_we", we, 1);
    check("sw_be", be, 4'b1111);
    check("sw_wdata", wdata, 32'hDEADBEEF);
    check("sw_addr", addr, 32'h100);
    check("sw_stall", stall, 0);
    tick();
    check("sw_wb_valid", wb_valid, 1);
    check("sw_wb_pc", wb_pc, 32'h40);
    check("sw_wb_rd", wb_rd, 5);
    check("sw_wb_ctrl", wb_ctrl, 8'h0A);
    check("sw_wb_data", wb_data, 0);
    idle();

    // Signed byte load from lane 3, response two cycles after the request
    set_op(32'h44, 32'h203, 0, 5'd6, ctl(1, 0, W_B, 0));
    ready = 1;
    #1;
    check("lb_req_valid", req_valid, 1);
    check("lb_be", be, 4'b1000);
    check("lb_we", we, 0);
    check("lb_stall0", stall, 1);
    tick();
    check("lb_bubble0", wb_valid, 0);
    ready = 0;
    #1;
    check("lb_stall1", stall, 1);
    check("lb_wait_no_req", req_valid, 0);
    tick();
    check("lb_bubble1", wb_valid, 0);
    rsp_valid = 1; rdata = 32'h80FFFFFF;
    #1;
    check("lb_stall2", stall, 0);
    tick();
    check("lb_wb_valid", wb_valid, 1);
    check("lb_wb_data", wb_data, 32'hFFFFFF80);
    check("lb_wb_rd", wb_rd, 6);
    idle();

    // Store half held in REQ for three cycles
    set_op(32'h48, 32'h12, 32'h0000ABCD, 5'd0, ctl(0, 1, W_H, 0));
    for (int i = 0; i < 3; i++) begin
      #1;
      check("sh_hold_req", req_valid, 1);
      check("sh_hold_be", be, 4'b1100);
      check("sh_hold_wdata", wdata, 32'hABCDABCD);
      check("sh_hold_stall", stall, 1);
      tick();
      check("sh_hold_bubble", wb_valid, 0);
    end
    ready = 1;
    #1;
    check("sh_acc_req", req_valid, 1);
    check("sh_acc_be", be, 4'b1100);
    check("sh_acc_addr", addr, 32'h12);
    check("sh_acc_stall", stall, 0);
    tick();
    check("sh_wb_valid", wb_valid, 1);
    idle();

    // Load word flushed while waiting; response later is dropped
    set_op(32'h50, 32'h300, 0, 5'd7, ctl(1, 0, W_W, 0));
    ready = 1;
    #1;
    check("lwf_req", req_valid, 1);
    tick();
    ready = 0; flush = 1;
    #1;
    check("lwf_stall", stall, 1);
    tick();
    flush = 0; rsp_valid = 1; rdata = 32'h12345678;
    #1;
    check("lwf_rsp_stall", stall, 0);
    tick();
    check("lwf_wb_valid", wb_valid, 0);
    check("lwf_wb_data", wb_data, 0);
    idle();
    set_op(32'h54, 32'h302, 0, 5'd8, ctl(1, 0, W_H, 1));
    ready = 1;
    #1;
    check("lhu_req", req_valid, 1);
    check("lhu_be", be, 4'b1100);
    tick();
    ready = 0; rsp_valid = 1; rdata = 32'h80010000;
    #1;
    check("lhu_stall", stall, 0);
    tick();
    check("lhu_wb_valid", wb_valid, 1);
    check("lhu_wb_data", wb_data, 32'h00008001);
    idle();

    // Flush and response in the same WAIT cycle, then a plain ALU op
    set_op(32'h60, 32'h400, 0, 5'd9, ctl(1, 0, W_W, 1));
    ready = 1;
    #1;
    tick();
    ready = 0; flush = 1; rsp_valid = 1; rdata = 32'hCAFEF00D;
    #1;
    check("fr_stall", stall, 0);
    tick();
    check("fr_wb_valid", wb_valid, 0);
    check("fr_wb_data", wb_data, 0);
    idle();
    set_op(32'h64, 32'h77, 0, 5'd10, 8'h40);
    #1;
    check("alu_stall", stall, 0);
    check("alu_req", req_valid, 0);
    tick();
    check("alu_wb_valid", wb_valid, 1);
    check("alu_wb_alu", wb_alu, 32'h77);
    check("alu_wb_ctrl", wb_ctrl, 8'h40);
    check("alu_wb_data", wb_data, 0);
    idle();

    // Flush in IDLE suppresses the request
    set_op(32'h68, 32'h104, 32'h11, 5'd0, ctl(0, 1, W_W, 0));
    ready = 1; flush = 1;
    #1;
    check("fi_req", req_valid, 0);
    check("fi_stall", stall, 0);
    tick();
    check("fi_wb_valid", wb_valid, 0);
    idle();

    // Reset while waiting; late response afterwards is ignored
    set_op(32'h6C, 32'h500, 0, 5'd11, ctl(1, 0, W_W, 0));
    ready = 1;
    #1;
    tick();
    ready = 0;
    #1;
    check("rw_stall", stall, 1);
    reset_n = 0;
    #1;
    check("rw_req", req_valid, 0);
    check("rw_wb_pc", wb_pc, 0);
    reset_n = 1;
    idle();
    rsp_valid = 1; rdata = 32'hFFFFFFFF;
    #1;
    check("rw_late_stall", stall, 0);
    tick();
    check("rw_late_valid", wb_valid, 0);
    check("rw_late_data", wb_data, 0);
    idle();

    // Doubleword code on a 32-bit datapath behaves as word
    set_op(32'h74, 32'h8, 32'h11223344, 5'd0, ctl(0, 1, W_D, 0));
    ready = 1;
    #1;
    check("sd32_be", be, 4'b1111);
    check("sd32_wdata", wdata, 32'h11223344);
    tick();
    check("sd32_wb_valid", wb_valid, 1);
    idle();

    // Misaligned signed half at 0x103
    set_op(32'h70, 32'h103, 0, 5'd12, ctl(1, 0, W_H, 0));
    ready = 1;
`ifdef MEM_MISALIGN_TRAP_EN
    #1;
    check("mis_req", req_valid, 0);
    check("mis_stall", stall, 0);
    tick();
    check("mis_wb_valid", wb_valid, 1);
    check("mis_wb_flag", wb_mis, 1);
    check("mis_wb_data", wb_data, 0);
`else
    #1;
    check("mis_req", req_valid, 1);
    check("mis_be", be, 4'b1100);
    tick();
    ready = 0; rsp_valid = 1; rdata = 32'h80011234;
    #1;
    tick();
    check("mis_wb_valid", wb_valid, 1);
    check("mis_wb_flag", wb_mis, 0);
    check("mis_wb_data", wb_data, 32'hFFFF8001);
`endif
    idle();

    // 64-bit datapath: unsigned and signed word loads from the upper word
    set_op64(64'h4, 0, ctl(1, 0, W_W, 1));
    d64_ready = 1;
    #1;
    check("d64_lwu_req", d64_req_valid, 1);
    check("d64_lwu_be", d64_be, 8'hF0);
    check("d64_lwu_addr", d64_addr, 64'h4);
    tick();
    d64_ready = 0; d64_rsp_valid = 1; d64_rdata = 64'h80000000_00000000;
    #1;
    check("d64_lwu_stall", d64_stall, 0);
    tick();
    check("d64_lwu_valid", d64_wb_valid, 1);
    check("d64_lwu_data", d64_wb_data, 64'h00000000_80000000);
    check("d64_lwu_pc", d64_wb_pc, 64'h1000);
    check("d64_lwu_alu", d64_wb_alu, 64'h4);
    check("d64_lwu_rd", d64_wb_rd, 3);
    check("d64_lwu_ctrl", d64_wb_ctrl, 8'h29);
    check("d64_lwu_mis", d64_wb_mis, 0);
    idle();
    set_op64(64'h4, 0, ctl(1, 0, W_W, 0));
    d64_ready = 1;
    #1;
    tick();
    d64_ready = 0; d64_rsp_valid = 1; d64_rdata = 64'h80000000_00000000;
    #1;
    tick();
    check("d64_lw_data", d64_wb_data, 64'hFFFFFFFF_80000000);
    idle();

    // 64-bit stores: byte lane 5 and full doubleword
    set_op64(64'h5, 64'hAB, ctl(0, 1, W_B, 0));
    d64_ready = 1;
    #1;
    check("d64_sb_be", d64_be, 8'h20);
    check("d64_sb_wdata", d64_wdata, 64'hABABABAB_ABABABAB);
    check("d64_sb_we", d64_we, 1);
    tick();
    idle();
    set_op64(64'h8, 64'h01234567_89ABCDEF, ctl(0, 1, W_D, 0));
    d64_ready = 1;
    #1;
    check("d64_sd_be", d64_be, 8'hFF);
    check("d64_sd_wdata", d64_wdata, 64'h01234567_89ABCDEF);
    tick();
    check("d64_sd_valid", d64_wb_valid, 1);
    idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
